// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline stage register: a DEPTH-entry FIFO with the valid/allow_in
// handshake of the single-entry stage registers, plus flush and occupancy.
module pipe_stage_fifo #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 2,
  parameter bit          PASS_THRU = 1'b1,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prev_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              allow_in,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              next_allow_in,
  output logic [CNT_W-1:0]  count
);

  // One-bit pointers still exist for DEPTH=1; they are pinned to 0 by the wrap.
  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              not_full;
  logic              push;
  logic              pop;

  // Handshake decode and masked head read.
  always_comb begin
    not_full  = (count_q < CNT_FULL);
    out_valid = (count_q != '0);
    if (PASS_THRU) begin
      allow_in = not_full | next_allow_in;
    end else begin
      allow_in = not_full;
    end
    push     = prev_valid & allow_in & ~flush;
    pop      = out_valid & next_allow_in & ~flush;
    out_data = out_valid ? mem_q[rd_ptr_q] : '0;
    count    = count_q;
  end

  // Pointer and occupancy next state; flush clears everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage: written only on push, never reset (reads are masked).
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: two instances (DEPTH=4/no pass-through and
// DEPTH=2/pass-through) share stimulus and are tracked by queue models.
module tb_pipe_stage_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        prev_valid;
  logic [31:0] in_data;
  logic        flush;
  logic        next_allow_in;

  logic        u4_allow_in, u4_out_valid;
  logic [31:0] u4_out_data;
  logic [2:0]  u4_count;
  logic        u2_allow_in, u2_out_valid;
  logic [31:0] u2_out_data;
  logic [1:0]  u2_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          armed  = 1'b0;

  logic [31:0] q4[$];
  logic [31:0] q2[$];

  typedef struct {
    logic        pv;
    logic [31:0] d;
    logic        nai;
    logic [2:0]  cnt;
    logic        ov;
    logic [31:0] od;
    logic        ai;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  pipe_stage_fifo #(.DATA_W(32), .DEPTH(4), .PASS_THRU(1'b0)) u_d4 (
    .clk(clk), .reset(reset), .prev_valid(prev_valid), .in_data(in_data),
    .allow_in(u4_allow_in), .flush(flush), .out_valid(u4_out_valid),
    .out_data(u4_out_data), .next_allow_in(next_allow_in), .count(u4_count)
  );

  pipe_stage_fifo #(.DATA_W(32), .DEPTH(2), .PASS_THRU(1'b1)) u_d2 (
    .clk(clk), .reset(reset), .prev_valid(prev_valid), .in_data(in_data),
    .allow_in(u2_allow_in), .flush(flush), .out_valid(u2_out_valid),
    .out_data(u2_out_data), .next_allow_in(next_allow_in), .count(u2_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Compare both instances against their queue models for the current inputs.
  task automatic model_check();
    logic [31:0] exp_od;
    exp_od = (q4.size() != 0) ? q4[0] : 32'h0;
    chk("m4_count", 32'(u4_count), 32'(q4.size()));
    chk("m4_valid", 32'(u4_out_valid), 32'(q4.size() != 0));
    chk("m4_data",  u4_out_data, exp_od);
    chk("m4_allow", 32'(u4_allow_in), 32'(q4.size() < 4));
    exp_od = (q2.size() != 0) ? q2[0] : 32'h0;
    chk("m2_count", 32'(u2_count), 32'(q2.size()));
    chk("m2_valid", 32'(u2_out_valid), 32'(q2.size() != 0));
    chk("m2_data",  u2_out_data, exp_od);
    chk("m2_allow", 32'(u2_allow_in), 32'((q2.size() < 2) | next_allow_in));
  endtask

  // Advance the models by one clock edge; popped entries are scoreboarded.
  task automatic model_update();
    logic        psh, pp;
    logic [31:0] v;
    psh = prev_valid & (q4.size() < 4) & ~flush;
    pp  = (q4.size() != 0) & next_allow_in & ~flush;
    if (!reset || flush) q4.delete();
    else begin
      if (pp) begin v = q4.pop_front(); chk("sb_pop4", u4_out_data, v); end
      if (psh) q4.push_back(in_data);
    end
    psh = prev_valid & ((q2.size() < 2) | next_allow_in) & ~flush;
    pp  = (q2.size() != 0) & next_allow_in & ~flush;
    if (!reset || flush) q2.delete();
    else begin
      if (pp) begin v = q2.pop_front(); chk("sb_pop2", u2_out_data, v); end
      if (psh) q2.push_back(in_data);
    end
  endtask

  // Called just after a negedge with inputs settled; returns after the next one.
  task automatic tick();
    if (armed) model_check();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input logic pv, input logic [31:0] d, input logic nai, input logic fl);
    prev_valid    = pv;
    in_data       = d;
    next_allow_in = nai;
    flush         = fl;
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_cnt4"}, 32'(u4_count), 32'd0);
    chk({nm, "_ov4"},  32'(u4_out_valid), 32'd0);
    chk({nm, "_od4"},  u4_out_data, 32'h0);
    chk({nm, "_ai4"},  32'(u4_allow_in), 32'd1);
    chk({nm, "_cnt2"}, 32'(u2_count), 32'd0);
    chk({nm, "_od2"},  u2_out_data, 32'h0);
  endtask

  initial begin
    // Fill/drain expectations for the DEPTH=4, PASS_THRU=0 instance.
    tbl[0] = '{1'b1, 32'd1, 1'b0, 3'd0, 1'b0, 32'd0, 1'b1};
    tbl[1] = '{1'b1, 32'd2, 1'b0, 3'd1, 1'b1, 32'd1, 1'b1};
    tbl[2] = '{1'b1, 32'd3, 1'b0, 3'd2, 1'b1, 32'd1, 1'b1};
    tbl[3] = '{1'b1, 32'd4, 1'b0, 3'd3, 1'b1, 32'd1, 1'b1};
    tbl[4] = '{1'b0, 32'd0, 1'b0, 3'd4, 1'b1, 32'd1, 1'b0};
    tbl[5] = '{1'b0, 32'd0, 1'b1, 3'd4, 1'b1, 32'd1, 1'b0};
    tbl[6] = '{1'b0, 32'd0, 1'b1, 3'd3, 1'b1, 32'd2, 1'b1};
    tbl[7] = '{1'b0, 32'd0, 1'b1, 3'd2, 1'b1, 32'd3, 1'b1};
    tbl[8] = '{1'b0, 32'd0, 1'b1, 3'd1, 1'b1, 32'd4, 1'b1};
    tbl[9] = '{1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0, 1'b1};

    // Reset hold with live upstream traffic.
    reset = 1'b0;
    apply(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    armed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_idle("rst_hold");
      tick();
    end
    reset = 1'b1;
    apply(1'b0, 32'h0, 1'b0, 1'b0);
    chk_idle("rst_rel");
    tick();

    // Table-driven fill/drain.
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].pv, tbl[i].d, tbl[i].nai, 1'b0);
      chk($sformatf("fd%0d_cnt", i), 32'(u4_count), 32'(tbl[i].cnt));
      chk($sformatf("fd%0d_ov", i),  32'(u4_out_valid), 32'(tbl[i].ov));
      chk($sformatf("fd%0d_od", i),  u4_out_data, tbl[i].od);
      chk($sformatf("fd%0d_ai", i),  32'(u4_allow_in), 32'(tbl[i].ai));
      tick();
    end

    // Full pass-through on the DEPTH=2 instance.
    apply(1'b0, 32'h0, 1'b0, 1'b1); tick();
    apply(1'b1, 32'hA, 1'b0, 1'b0); tick();
    apply(1'b1, 32'hB, 1'b0, 1'b0); tick();
    apply(1'b1, 32'hC, 1'b1, 1'b0);
    chk("pt_full_cnt", 32'(u2_count), 32'd2);
    chk("pt_allow",    32'(u2_allow_in), 32'd1);
    chk("pt_head_a",   u2_out_data, 32'hA);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0);
    chk("pt_cnt_after", 32'(u2_count), 32'd2);
    chk("pt_head_b",    u2_out_data, 32'hB);
    tick();
    apply(1'b0, 32'h0, 1'b1, 1'b0); tick();
    chk("pt_head_c", u2_out_data, 32'hC);
    chk("pt_cnt_c",  32'(u2_count), 32'd1);
    tick();

    // Wrap-around with steady occupancy of one.
    apply(1'b0, 32'h0, 1'b0, 1'b1); tick();
    apply(1'b1, 32'h0F, 1'b0, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 32'h10 + 32'(i), 1'b1, 1'b0);
      chk($sformatf("wrap%0d_cnt", i), 32'(u4_count), 32'd1);
      chk($sformatf("wrap%0d_od", i), u4_out_data, (i == 0) ? 32'h0F : 32'h10 + 32'(i - 1));
      tick();
    end
    apply(1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap_last", u4_out_data, 32'h19);
    tick();

    // Flush beats a simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 32'h21 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    apply(1'b1, 32'h55, 1'b1, 1'b1);
    chk("fl_pre_cnt", 32'(u4_count), 32'd3);
    tick();
    apply(1'b0, 32'h0, 1'b0, 1'b0);
    chk_idle("fl_post");
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fl_no55", 32'(u4_out_data == 32'h55), 32'd0);
      tick();
    end

    // Backpressure holds the head stable while the queue fills.
    apply(1'b1, 32'h1234, 1'b0, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 32'h1, 1'b0, 1'b0);
      chk($sformatf("bp%0d_od4", i), u4_out_data, 32'h1234);
      chk($sformatf("bp%0d_cnt4", i), 32'(u4_count), (i < 3) ? 32'(i + 1) : 32'd4);
      chk($sformatf("bp%0d_od2", i), u2_out_data, 32'h1234);
      chk($sformatf("bp%0d_cnt2", i), 32'(u2_count), (i < 1) ? 32'd1 : 32'd2);
      tick();
    end

    // Reset while holding data.
    reset = 1'b0;
    apply(1'b1, 32'h77, 1'b1, 1'b0); tick();
    reset = 1'b1;
    apply(1'b0, 32'h0, 1'b0, 1'b0);
    chk_idle("rst_full");
    tick();

    // Random traffic against the models.
    for (int i = 0; i < 300; i++) begin
      apply(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
